// File: rtl/neg_2s_serial_pkg.sv
// Shared encodings for the digit-serial sign unit: FSM states, mode codes and
// the rule deciding whether an operand is negated.
package neg_2s_serial_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        MODE_PASS = 2'b00,
        MODE_NEG  = 2'b01,
        MODE_ABS  = 2'b10,
        MODE_NABS = 2'b11
    } mode_e;

    // ABS negates negative operands, NABS negates non-negative ones (zero included).
    function automatic logic needs_negate(input logic [1:0] mode, input logic sign);
        logic neg;
        neg = 1'b0;
        unique case (mode)
            MODE_PASS: neg = 1'b0;
            MODE_NEG:  neg = 1'b1;
            MODE_ABS:  neg = sign;
            MODE_NABS: neg = ~sign;
            default:   neg = 1'b0;
        endcase
        return neg;
    endfunction

endpackage

// File: rtl/neg_2s_serial_digit.sv
// One digit slice of the serial negator: conditional invert followed by a
// half-adder ripple that adds the incoming carry.
module neg_digit #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] d,
    input  logic             inv,
    input  logic             cin,
    output logic [DIGIT-1:0] sum,
    output logic             cout
);

    logic [DIGIT-1:0] x;
    logic [DIGIT:0]   c;

    always_comb begin
        x    = d ^ {DIGIT{inv}};
        sum  = '0;
        c    = '0;
        c[0] = cin;
        for (int i = 0; i < DIGIT; i++) begin
            sum[i]   = x[i] ^ c[i];
            c[i+1]   = x[i] & c[i];
        end
        cout = c[DIGIT];
    end

endmodule

// File: rtl/neg_2s_serial.sv
// Digit-serial two's-complement sign unit (PASS/NEG/ABS/NABS), LSB-first with a
// registered carry between digits and valid/ready handshakes on both sides.
module neg_2s_serial
    import neg_2s_serial_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_ovf,
    output logic             out_zero
);

    // Handshake: a transfer happens on a rising edge where valid and ready are
    // both high; valid never depends on ready and outputs hold until taken.

    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CW-1:0]    CNT_LAST = CW'(NDIG - 1);
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]  sh_q, sh_d;
    logic              carry_q, carry_d;
    logic              neg_q, neg_d;
    logic              ovf_q, ovf_d;

    logic              accept_neg;
    logic [DIGIT-1:0]  dig_sum;
    logic              dig_cout;
    logic [WIDTH-1:0]  sh_shifted;

    neg_digit #(
        .DIGIT (DIGIT)
    ) u_digit (
        .d    (sh_q[DIGIT-1:0]),
        .inv  (neg_q),
        .cin  (carry_q),
        .sum  (dig_sum),
        .cout (dig_cout)
    );

    // Result digits enter at the top so the word is fully realigned after NDIG shifts.
    generate
        if (DIGIT == WIDTH) begin : g_single
            assign sh_shifted = dig_sum;
        end else begin : g_multi
            assign sh_shifted = {dig_sum, sh_q[WIDTH-1:DIGIT]};
        end
    endgenerate

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sh_d       = sh_q;
        carry_d    = carry_q;
        neg_d      = neg_q;
        ovf_d      = ovf_q;
        accept_neg = 1'b0;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        out_data   = '0;
        out_ovf    = 1'b0;
        out_zero   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept_neg = needs_negate(mode, in_data[WIDTH-1]);
                    sh_d       = in_data;
                    carry_d    = accept_neg;
                    neg_d      = accept_neg;
                    // Only the most-negative value wraps back onto itself when negated.
                    ovf_d      = accept_neg & (in_data == MOST_NEG);
                    cnt_d      = '0;
                    state_d    = ST_RUN;
                end
            end
            ST_RUN: begin
                sh_d    = sh_shifted;
                carry_d = dig_cout;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                out_data  = sh_q;
                out_ovf   = ovf_q;
                out_zero  = (sh_q == '0);
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            sh_q    <= '0;
            carry_q <= 1'b0;
            neg_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            carry_q <= carry_d;
            neg_q   <= neg_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: tb/tb_neg_2s_serial.sv
// Bench for neg_2s_serial across four WIDTH/DIGIT configurations, each with its
// own driver, scoreboard queue, monitor and arithmetic reference model.
module tb_neg_2s_serial;

    localparam logic [1:0] M_PASS = 2'b00;
    localparam logic [1:0] M_NEG  = 2'b01;
    localparam logic [1:0] M_ABS  = 2'b10;
    localparam logic [1:0] M_NABS = 2'b11;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    function automatic void check(input string name, input longint unsigned act,
                                  input longint unsigned exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endfunction

    for (genvar g = 0; g < 4; g++) begin : cfg
        localparam int W  = (g == 0) ? 16 : (g == 1) ? 8 : (g == 2) ? 32 : 16;
        localparam int D  = (g == 0) ? 4  : (g == 1) ? 1 : (g == 2) ? 8  : 16;
        localparam int ND = W / D;

        logic         rst_n = 1'b0;
        logic         in_valid = 1'b0;
        logic         in_ready;
        logic [W-1:0] in_data = '0;
        logic [1:0]   mode = 2'b00;
        logic         out_valid;
        logic         out_ready = 1'b1;
        logic [W-1:0] out_data;
        logic         out_ovf;
        logic         out_zero;

        neg_2s_serial #(
            .WIDTH (W),
            .DIGIT (D)
        ) dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid),
            .in_ready  (in_ready),
            .in_data   (in_data),
            .mode      (mode),
            .out_valid (out_valid),
            .out_ready (out_ready),
            .out_data  (out_data),
            .out_ovf   (out_ovf),
            .out_zero  (out_zero)
        );

        logic [W+1:0] exp_q[$];
        int           acc_q[$];
        int           edges = 0;
        bit           lat_done = 1'b0;
        logic [W+1:0] held = '0;
        bit           rdy_rand = 1'b0;
        bit           done_f = 1'b0;

        always @(posedge clk) edges <= edges + 1;

        function automatic void chk(input string name, input longint unsigned act,
                                    input longint unsigned exp);
            check($sformatf("w%0d_d%0d_%s", W, D, name), act, exp);
        endfunction

        // Reference: signed arithmetic on the operand value; {ovf, zero, result}.
        function automatic logic [W+1:0] model(input logic [1:0] m, input logic [W-1:0] v);
            longint       sv, r, maxv;
            logic [W-1:0] res;
            sv   = longint'($signed(v));
            maxv = (longint'(1) <<< (W - 1)) - 1;
            case (m)
                M_PASS:  r = sv;
                M_NEG:   r = -sv;
                M_ABS:   r = (sv < 0) ? -sv : sv;
                default: r = (sv > 0) ? -sv : sv;
            endcase
            res = r[W-1:0];
            return {(r > maxv), (res == '0), res};
        endfunction

        always @(posedge clk) begin
            if (rdy_rand) begin
                #1;
                if (rdy_rand) out_ready = 1'($urandom_range(0, 1));
            end
        end

        always @(negedge clk) begin
            if (!rst_n) begin
                exp_q.delete();
                acc_q.delete();
                lat_done = 1'b0;
            end else if (out_valid) begin
                chk("in_ready_busy", in_ready, 0);
                if (exp_q.size() == 0) begin
                    chk("unexpected_out_valid", out_valid, 0);
                end else begin
                    if (!lat_done) begin
                        chk("latency", edges - acc_q[0], ND);
                        chk("result", {out_ovf, out_zero, out_data}, exp_q[0]);
                        held     = {out_ovf, out_zero, out_data};
                        lat_done = 1'b1;
                    end else begin
                        chk("hold_stable", {out_ovf, out_zero, out_data}, held);
                    end
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        void'(acc_q.pop_front());
                        lat_done = 1'b0;
                    end
                end
            end
        end

        // Called just after a rising edge; returns just after the accept edge.
        task automatic send(input logic [1:0] m, input logic [W-1:0] v, output int waited);
            waited   = 0;
            in_valid = 1'b1;
            mode     = m;
            in_data  = v;
            do begin
                @(negedge clk);
                waited++;
            end while (!in_ready && waited < 400);
            chk("accept", in_ready, 1);
            if (in_ready) begin
                exp_q.push_back(model(m, v));
                acc_q.push_back(edges + 1);
            end
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            mode     = 2'($urandom_range(0, 3));
            in_data  = W'({$urandom, $urandom});
        endtask

        task automatic drain();
            int k;
            k = 0;
            while (exp_q.size() != 0 && k < 2000) begin
                @(posedge clk);
                #1;
                k++;
            end
            chk("drain", exp_q.size(), 0);
        endtask

        task automatic check_reset_outputs();
            chk("rst_in_ready", in_ready, 1);
            chk("rst_out_valid", out_valid, 0);
            chk("rst_out_data", out_data, 0);
            chk("rst_out_ovf", out_ovf, 0);
            chk("rst_out_zero", out_zero, 0);
        endtask

        initial begin
            logic [W-1:0] mn;
            logic [W-1:0] v;
            logic [1:0]   m;
            logic [W+1:0] snap;
            int           w;
            int           k;
            mn = {1'b1, {(W-1){1'b0}}};

            repeat (2) @(posedge clk);
            @(negedge clk);
            check_reset_outputs();
            @(posedge clk);
            #1 rst_n = 1'b1;

            rdy_rand = 1'b1;
            send(M_NEG,  W'(1),    w);
            send(M_ABS,  W'(-123), w);
            send(M_ABS,  W'(123),  w);
            send(M_NABS, W'(123),  w);
            send(M_PASS, W'('h1234), w);
            send(M_NEG,  mn,       w);
            send(M_ABS,  mn,       w);
            send(M_NEG,  W'(0),    w);
            send(M_NABS, W'(0),    w);
            send(M_PASS, mn,       w);
            rdy_rand  = 1'b0;
            out_ready = 1'b1;
            drain();

            // Backpressure in DONE, then the very next edge must accept.
            out_ready = 1'b0;
            send(M_NEG, W'(5), w);
            k = 0;
            do begin
                @(negedge clk);
                k++;
            end while (!out_valid && k < 4 * ND + 8);
            chk("bp_valid", out_valid, 1);
            snap = {out_ovf, out_zero, out_data};
            repeat (5) begin
                @(negedge clk);
                chk("bp_hold", {out_valid, out_ovf, out_zero, out_data}, {1'b1, snap});
                chk("bp_in_ready", in_ready, 0);
            end
            @(posedge clk);
            #1 out_ready = 1'b1;
            @(posedge clk);
            #1;
            chk("bp_release_valid", out_valid, 0);
            chk("bp_release_ready", in_ready, 1);
            send(M_NABS, W'(9), w);
            chk("bp_next_accept_wait", w, 1);
            drain();

            // Reset during RUN aborts the operation.
            send(M_NEG, W'(7), w);
            if (ND > 1) begin
                @(posedge clk);
                #1;
            end
            rst_n = 1'b0;
            @(negedge clk);
            check_reset_outputs();
            @(posedge clk);
            #1 rst_n = 1'b1;
            repeat (ND + 3) begin
                @(negedge clk);
                chk("abort_no_valid", out_valid, 0);
            end
            chk("abort_in_ready", in_ready, 1);
            @(posedge clk);
            #1;
            send(M_NEG, W'(2), w);
            drain();

            rdy_rand = 1'b1;
            repeat (30) begin
                m = 2'($urandom_range(0, 3));
                case ($urandom_range(0, 5))
                    0:       v = '0;
                    1:       v = mn;
                    2:       v = '1;
                    3:       v = W'(1);
                    default: v = W'({$urandom, $urandom});
                endcase
                send(m, v, w);
                if ($urandom_range(0, 3) == 0) begin
                    @(posedge clk);
                    #1;
                end
            end
            rdy_rand  = 1'b0;
            out_ready = 1'b1;
            drain();
            done_f = 1'b1;
        end
    end

    initial begin
        int t;
        t = 0;
        while (!(cfg[0].done_f && cfg[1].done_f && cfg[2].done_f && cfg[3].done_f)
               && t < 60000) begin
            @(posedge clk);
            t++;
        end
        check("all_configs_done",
              {cfg[3].done_f, cfg[2].done_f, cfg[1].done_f, cfg[0].done_f}, 4'hF);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
